// File: rtl/keccak_sponge_ctrl_if.sv
// Handshake bundle between the sponge sequencer, its requester, the padder,
// the Keccak-f[1600] core and the squeeze consumer.
interface keccak_sponge_ctrl_if #(
    parameter int SQ_W = 8
);
    logic            start;
    logic [1:0]      mode;
    logic [SQ_W-1:0] out_blocks;
    logic            busy;
    logic            done;

    logic [63:0]     s_data;
    logic            s_valid;
    logic            s_last;
    logic [1:0]      s_bytes;
    logic            s_ready;

    logic [63:0]     pad_in;
    logic            pad_in_ready;
    logic            pad_is_last;
    logic [1:0]      pad_byte_num;
    logic [1:0]      pad_mode;
    logic            pad_reset;
    logic            pad_buffer_full;
    logic            pad_f_ack;

    logic            perm_start;
    logic            perm_absorb;
    logic            perm_done;

    logic            sq_valid;
    logic            sq_last;
    logic            sq_ack;

    modport master (
        input  start, mode, out_blocks, s_data, s_valid, s_last, s_bytes,
               pad_buffer_full, perm_done, sq_ack,
        output busy, done, s_ready, pad_in, pad_in_ready, pad_is_last,
               pad_byte_num, pad_mode, pad_reset, pad_f_ack,
               perm_start, perm_absorb, sq_valid, sq_last
    );

    modport slave (
        output start, mode, out_blocks, s_data, s_valid, s_last, s_bytes,
               pad_buffer_full, perm_done, sq_ack,
        input  busy, done, s_ready, pad_in, pad_in_ready, pad_is_last,
               pad_byte_num, pad_mode, pad_reset, pad_f_ack,
               perm_start, perm_absorb, sq_valid, sq_last
    );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Sequences one SHAKE128/256 call: absorb words into the padder, permute per full block, squeeze N blocks.
// Word path is combinational (zero latency); s_ready drops while the padder block is full or after the last word.
module keccak_sponge_ctrl #(
    parameter int SQ_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    keccak_sponge_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ABSORB, PERM_A, SQUEEZE, PERM_S, DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [SQ_W-1:0] blk_left_q, blk_left_d;
    logic            last_seen_q, last_seen_d;
    logic            s_ready_c;
    logic            accept_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            blk_left_q  <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            blk_left_q  <= blk_left_d;
            last_seen_q <= last_seen_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        blk_left_d      = blk_left_q;
        last_seen_d     = last_seen_q;
        s_ready_c       = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.pad_f_ack   = 1'b0;
        bus.perm_start  = 1'b0;
        bus.perm_absorb = 1'b0;
        bus.sq_valid    = 1'b0;
        bus.sq_last     = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_d      = (bus.mode == 2'b00) ? 2'b00 : 2'b10;
                        blk_left_d  = (bus.out_blocks == '0) ? SQ_W'(1) : bus.out_blocks;
                        last_seen_d = 1'b0;
                        state_d     = ABSORB;
                    end
                end
                ABSORB: begin
                    bus.busy  = 1'b1;
                    s_ready_c = ~bus.pad_buffer_full & ~last_seen_q;
                    if (bus.s_valid && s_ready_c && bus.s_last) begin
                        last_seen_d = 1'b1;
                    end
                    // Block hand-off and permutation launch happen in the same cycle.
                    if (bus.pad_buffer_full) begin
                        bus.pad_f_ack   = 1'b1;
                        bus.perm_start  = 1'b1;
                        bus.perm_absorb = 1'b1;
                        state_d         = PERM_A;
                    end
                end
                PERM_A: begin
                    bus.busy = 1'b1;
                    if (bus.perm_done) begin
                        state_d = last_seen_q ? SQUEEZE : ABSORB;
                    end
                end
                SQUEEZE: begin
                    bus.busy     = 1'b1;
                    bus.sq_valid = 1'b1;
                    bus.sq_last  = (blk_left_q == SQ_W'(1));
                    if (bus.sq_ack) begin
                        if (blk_left_q == SQ_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            blk_left_d     = blk_left_q - SQ_W'(1);
                            bus.perm_start = 1'b1;
                            state_d        = PERM_S;
                        end
                    end
                end
                PERM_S: begin
                    bus.busy = 1'b1;
                    if (bus.perm_done) begin
                        state_d = SQUEEZE;
                    end
                end
                DONE: begin
                    bus.done = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign accept_c         = bus.s_valid & s_ready_c;
    assign bus.s_ready      = s_ready_c;
    assign bus.pad_in       = reset ? bus.s_data : 64'd0;
    assign bus.pad_in_ready = accept_c;
    assign bus.pad_is_last  = accept_c & bus.s_last;
    assign bus.pad_byte_num = reset ? bus.s_bytes : 2'b00;
    assign bus.pad_mode     = reset ? mode_q : 2'b00;
    assign bus.pad_reset    = ~reset | (state_q == DONE);
endmodule
